branch_predictor: RTL and testbench

//  Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 148 ++++++++++++++
 tb/tb_branch_predictor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: mode selectors, 2-bit counter
// encodings and a constant-evaluable clog2.
package bp_pkg;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;
    localparam int MODE_GSHARE  = 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next state of a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else if (ctr != CTR_SNT) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: tagged BTB plus 2-bit PHT, indexed by PC
// (bimodal) or PC xor global history (gshare), trained from EX/MEM.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENTRIES = 64,
    parameter int GHR_BITS    = 6,
    parameter int MODE        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic [GHR_BITS-1:0]   upd_ghr,
    input  logic                  upd_is_jump,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispred
);

    localparam int IDX_W = clog2(NUM_ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
    localparam bit LEARN = (MODE != MODE_STATIC);

    logic                  valid_reg  [NUM_ENTRIES];
    logic [TAG_W-1:0]      tag_reg    [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] target_reg [NUM_ENTRIES];
    logic                  jump_reg   [NUM_ENTRIES];
    logic [1:0]            ctr_reg    [NUM_ENTRIES];
    logic [GHR_BITS-1:0]   ghr_reg;
    logic [31:0]           branches_reg;
    logic [31:0]           mispred_reg;

    function automatic logic [IDX_W-1:0] index_of(input logic [DATA_WIDTH-1:0] pc,
                                                  input logic [GHR_BITS-1:0]   ghr);
        logic [IDX_W-1:0] base;
        base = pc[IDX_W+1:2];
        if (MODE == MODE_GSHARE) begin
            return base ^ IDX_W'(ghr);
        end
        return base;
    endfunction

    // Lookup path: purely combinational from registered state.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = index_of(if_pc, ghr_reg);
    assign lk_tag = if_pc[DATA_WIDTH-1:IDX_W+2];

    always_comb begin
        lk_hit      = LEARN && !rst && valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
        pred_hit    = lk_hit;
        pred_taken  = lk_hit && (jump_reg[lk_idx] || ctr_reg[lk_idx][1]);
        pred_target = lk_hit ? target_reg[lk_idx] : '0;
        pred_ghr    = rst ? '0 : ghr_reg;
    end

    // Update path: index with the history the instruction was predicted under.
    logic [IDX_W-1:0]       up_idx;
    logic [TAG_W-1:0]       up_tag;
    logic                   up_hit;
    logic                   act_taken;
    logic                   tbl_we;
    logic [1:0]             up_ctr_next;
    logic [NUM_ENTRIES-1:0] entry_we;

    assign up_idx    = index_of(upd_pc, upd_ghr);
    assign up_tag    = upd_pc[DATA_WIDTH-1:IDX_W+2];
    assign up_hit    = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
    assign act_taken = upd_taken || upd_is_jump;
    assign tbl_we    = LEARN && upd_valid && (up_hit || act_taken);

    bp_sat_counter u_ctr (
        .ctr      (ctr_reg[up_idx]),
        .inc      (act_taken),
        .ctr_next (up_ctr_next)
    );

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_we
            assign entry_we[gi] = tbl_we && (up_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                jump_reg[i]   <= 1'b0;
                ctr_reg[i]    <= CTR_WNT;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (entry_we[i]) begin
                    valid_reg[i] <= 1'b1;
                    tag_reg[i]   <= up_tag;
                    ctr_reg[i]   <= up_hit ? up_ctr_next : CTR_WT;
                    // Target/type only change on a taken outcome; a fresh allocation is always taken.
                    if (act_taken) begin
                        target_reg[i] <= upd_target;
                        jump_reg[i]   <= upd_is_jump;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg <= '0;
        end else if (LEARN && upd_valid && !upd_is_jump) begin
            ghr_reg <= GHR_BITS'({ghr_reg, upd_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branches_reg <= '0;
            mispred_reg  <= '0;
        end else begin
            if (upd_valid && branches_reg != 32'hFFFF_FFFF) begin
                branches_reg <= branches_reg + 32'd1;
            end
            if (upd_valid && upd_mispredict && mispred_reg != 32'hFFFF_FFFF) begin
                mispred_reg <= mispred_reg + 32'd1;
            end
        end
    end

    assign stat_branches = branches_reg;
    assign stat_mispred  = mispred_reg;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal, gshare and static predictors share one stimulus
// stream; expectations are queued by hand and checked against the outputs.
module tb_branch_predictor;

    localparam int BI_HIT = 0, BI_TAKEN = 1, BI_TGT = 2, BI_GHR = 3, BI_BR = 4, BI_MIS = 5;
    localparam int GS_HIT = 6, GS_TAKEN = 7, GS_TGT = 8, GS_GHR = 9, GS_BR = 10, GS_MIS = 11;
    localparam int ST_HIT = 12, ST_TAKEN = 13, ST_GHR = 14, ST_BR = 15, ST_MIS = 16;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        bi_hit, bi_taken, gs_hit, gs_taken, st_hit, st_taken;
    logic [31:0] bi_tgt, gs_tgt, st_tgt;
    logic [5:0]  bi_ghr, gs_ghr, st_ghr;
    logic [31:0] bi_br, bi_mis, gs_br, gs_mis, st_br, st_mis;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    branch_predictor #(.DATA_WIDTH(32), .NUM_ENTRIES(64), .GHR_BITS(6), .MODE(1)) u_bi (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_hit(bi_hit), .pred_taken(bi_taken), .pred_target(bi_tgt), .pred_ghr(bi_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(bi_br), .stat_mispred(bi_mis)
    );

    branch_predictor #(.DATA_WIDTH(32), .NUM_ENTRIES(64), .GHR_BITS(6), .MODE(2)) u_gs (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_hit(gs_hit), .pred_taken(gs_taken), .pred_target(gs_tgt), .pred_ghr(gs_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(gs_br), .stat_mispred(gs_mis)
    );

    branch_predictor #(.DATA_WIDTH(32), .NUM_ENTRIES(64), .GHR_BITS(6), .MODE(0)) u_st (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_hit(st_hit), .pred_taken(st_taken), .pred_target(st_tgt), .pred_ghr(st_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .stat_branches(st_br), .stat_mispred(st_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            BI_HIT:   return {31'd0, bi_hit};
            BI_TAKEN: return {31'd0, bi_taken};
            BI_TGT:   return bi_tgt;
            BI_GHR:   return {26'd0, bi_ghr};
            BI_BR:    return bi_br;
            BI_MIS:   return bi_mis;
            GS_HIT:   return {31'd0, gs_hit};
            GS_TAKEN: return {31'd0, gs_taken};
            GS_TGT:   return gs_tgt;
            GS_GHR:   return {26'd0, gs_ghr};
            GS_BR:    return gs_br;
            GS_MIS:   return gs_mis;
            ST_HIT:   return {31'd0, st_hit};
            ST_TAKEN: return {31'd0, st_taken};
            ST_GHR:   return {26'd0, st_ghr};
            ST_BR:    return st_br;
            ST_MIS:   return st_mis;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.name, obs, e.exp);
            end
            $display("check %-20s observed %h expected %h", e.name, obs, e.exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic jp,
                       input logic [31:0] tg, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_is_jump    = jp;
        upd_target     = tg;
        upd_mispredict = mis;
        upd_ghr        = gs_ghr;
        @(posedge clk);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; if_pc = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk(BI_HIT, 0, "rst_bi_hit"); chk(BI_TAKEN, 0, "rst_bi_taken");
        chk(BI_TGT, 0, "rst_bi_tgt"); chk(GS_GHR, 0, "rst_gs_ghr");
        chk(GS_HIT, 0, "rst_gs_hit"); chk(BI_BR, 0, "rst_bi_br");
        chk(GS_MIS, 0, "rst_gs_mis"); chk(ST_BR, 0, "rst_st_br");
        drain();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(BI_HIT, 0, "post_rst_bi_hit"); chk(GS_HIT, 0, "post_rst_gs_hit");
        drain();

        // Allocate, then one not-taken drops to weak not-taken
        upd(32'h100, 1, 0, 32'h80, 0);
        chk(BI_HIT, 1, "alloc_bi_hit"); chk(BI_TAKEN, 1, "alloc_bi_taken");
        chk(BI_TGT, 32'h80, "alloc_bi_tgt"); chk(GS_GHR, 1, "alloc_gs_ghr");
        chk(GS_HIT, 0, "alloc_gs_live_ghr"); chk(ST_HIT, 0, "static_hit");
        chk(ST_TAKEN, 0, "static_taken");
        drain();
        upd(32'h100, 0, 0, 32'h80, 0);
        chk(BI_HIT, 1, "nt_bi_hit"); chk(BI_TAKEN, 0, "nt_bi_taken");
        chk(BI_TGT, 32'h80, "nt_bi_tgt"); chk(GS_GHR, 2, "nt_gs_ghr");
        chk(BI_BR, 2, "nt_bi_br"); chk(ST_BR, 2, "nt_st_br"); chk(ST_GHR, 0, "static_ghr");
        drain();

        // Saturation at strongly taken
        repeat (4) upd(32'h100, 1, 0, 32'h80, 0);
        chk(BI_TAKEN, 1, "sat_bi_taken"); chk(BI_GHR, 47, "sat_bi_ghr");
        drain();
        upd(32'h100, 0, 0, 32'h80, 0);
        chk(BI_TAKEN, 1, "st_to_wt_taken");
        drain();
        upd(32'h100, 0, 0, 32'h80, 0);
        chk(BI_TAKEN, 0, "wt_to_wnt_taken"); chk(BI_HIT, 1, "wt_to_wnt_hit");
        chk(BI_GHR, 60, "wt_to_wnt_ghr"); chk(BI_BR, 8, "sat_bi_br");
        drain();

        // Tag conflict replaces the entry
        upd(32'h100, 1, 0, 32'h80, 0);
        upd(32'h200, 1, 0, 32'h300, 0);
        if_pc = 32'h100;
        chk(BI_HIT, 0, "conflict_old_hit"); chk(BI_TAKEN, 0, "conflict_old_taken");
        chk(BI_TGT, 0, "conflict_old_tgt");
        drain();
        if_pc = 32'h200;
        chk(BI_HIT, 1, "conflict_new_hit"); chk(BI_TAKEN, 1, "conflict_new_taken");
        chk(BI_TGT, 32'h300, "conflict_new_tgt"); chk(GS_GHR, 51, "conflict_gs_ghr");
        chk(GS_HIT, 0, "conflict_gs_hit");
        drain();

        // History shifting and jump handling
        upd(32'h40, 1, 0, 32'h10, 0);
        upd(32'h40, 1, 0, 32'h10, 0);
        upd(32'h40, 0, 0, 32'h10, 0);
        chk(GS_GHR, 30, "ttn_gs_ghr"); chk(BI_GHR, 30, "ttn_bi_ghr");
        drain();
        upd(32'h40, 1, 1, 32'h400, 0);
        if_pc = 32'h40;
        chk(GS_GHR, 30, "jal_gs_ghr"); chk(GS_HIT, 1, "jal_gs_hit");
        chk(GS_TAKEN, 1, "jal_gs_taken"); chk(GS_TGT, 32'h400, "jal_gs_tgt");
        chk(BI_TAKEN, 1, "jal_bi_taken"); chk(BI_TGT, 32'h400, "jal_bi_tgt");
        drain();
        repeat (3) upd(32'h40, 0, 0, 32'h10, 0);
        chk(BI_HIT, 1, "jmp_lowctr_hit"); chk(BI_TAKEN, 1, "jmp_lowctr_taken");
        chk(BI_TGT, 32'h400, "jmp_lowctr_tgt"); chk(BI_GHR, 48, "jmp_lowctr_ghr");
        chk(BI_BR, 17, "jmp_bi_br"); chk(ST_BR, 17, "jmp_st_br");
        chk(ST_HIT, 0, "jmp_st_hit"); chk(ST_GHR, 0, "jmp_st_ghr");
        drain();

        // Mid-operation reset discards the same-cycle update
        upd(32'h100, 1, 0, 32'h80, 0);
        upd(32'h200, 1, 0, 32'h300, 0);
        upd(32'h40, 1, 0, 32'h10, 1);
        upd(32'h100, 0, 0, 32'h80, 1);
        chk(BI_BR, 21, "pre_rst_bi_br"); chk(BI_MIS, 2, "pre_rst_bi_mis");
        chk(GS_MIS, 2, "pre_rst_gs_mis"); chk(ST_MIS, 2, "pre_rst_st_mis");
        drain();
        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_is_jump = 1'b0;
        upd_target = 32'h300; upd_mispredict = 1'b1; upd_ghr = gs_ghr;
        @(posedge clk);
        #1;
        rst = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
        chk(BI_BR, 0, "midrst_bi_br"); chk(BI_MIS, 0, "midrst_bi_mis");
        chk(GS_BR, 0, "midrst_gs_br"); chk(ST_BR, 0, "midrst_st_br");
        chk(GS_GHR, 0, "midrst_gs_ghr"); chk(BI_GHR, 0, "midrst_bi_ghr");
        drain();
        if_pc = 32'h100; chk(BI_HIT, 0, "midrst_hit_100"); chk(GS_HIT, 0, "midrst_gs_hit_100"); drain();
        if_pc = 32'h200; chk(BI_HIT, 0, "midrst_hit_200"); chk(GS_HIT, 0, "midrst_gs_hit_200"); drain();
        if_pc = 32'h40;  chk(BI_HIT, 0, "midrst_hit_40");  chk(GS_HIT, 0, "midrst_gs_hit_40");  drain();

        // Same-cycle lookup and update of one PC sees the old entry
        @(posedge clk);
        #1;
        if_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_is_jump = 1'b0;
        upd_target = 32'h80; upd_mispredict = 1'b0; upd_ghr = gs_ghr;
        chk(BI_HIT, 0, "same_cyc_bi_hit"); chk(GS_HIT, 0, "same_cyc_gs_hit");
        chk(BI_TGT, 0, "same_cyc_bi_tgt");
        drain();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        chk(BI_HIT, 1, "after_bi_hit"); chk(BI_TAKEN, 1, "after_bi_taken");
        chk(BI_TGT, 32'h80, "after_bi_tgt"); chk(GS_HIT, 0, "after_gs_hit");
        chk(BI_BR, 1, "after_bi_br");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
